// File: rtl/ahb_master_arbiter_pkg.sv
// Shared AHB-Lite encodings and the owner type used by the two-master arbiter.
package ahb_master_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  // BUSY and IDLE never count as a request.
  function automatic logic is_req(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_arb_req_buf.sv
// One-entry request buffer holding a master's address phase that lost arbitration
// or arrived while the output slot was busy.
module ahb_arb_req_buf #(
  parameter int W = 41
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] req_i,
  output logic         valid_o,
  output logic [W-1:0] req_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] req_q, req_d;

  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    if (clear) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      req_d   = req_i;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign valid_o = valid_q;
  assign req_o   = req_q;

endmodule

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter: merges the fetch (M0) and load/store (M1) ports
// onto one registered bus address phase, issuing every beat as NONSEQ/SINGLE.
module ahb_master_arbiter
  import ahb_master_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RR_EN      = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [ADDR_WIDTH-1:0] m0_haddr,
  input  logic [1:0]            m0_htrans,
  input  logic                  m0_hwrite,
  input  logic                  m0_hmastlock,
  input  logic [2:0]            m0_hsize,
  input  logic [2:0]            m0_hburst,
  input  logic [3:0]            m0_hprot,
  input  logic [DATA_WIDTH-1:0] m0_hwdata,
  output logic [DATA_WIDTH-1:0] m0_hrdata,
  output logic                  m0_hready,
  output logic                  m0_hresp,
  input  logic [ADDR_WIDTH-1:0] m1_haddr,
  input  logic [1:0]            m1_htrans,
  input  logic                  m1_hwrite,
  input  logic                  m1_hmastlock,
  input  logic [2:0]            m1_hsize,
  input  logic [2:0]            m1_hburst,
  input  logic [3:0]            m1_hprot,
  input  logic [DATA_WIDTH-1:0] m1_hwdata,
  output logic [DATA_WIDTH-1:0] m1_hrdata,
  output logic                  m1_hready,
  output logic                  m1_hresp,
  output logic [ADDR_WIDTH-1:0] s_haddr,
  output logic                  s_hwrite,
  output logic [1:0]            s_htrans,
  output logic [2:0]            s_hsize,
  output logic [2:0]            s_hburst,
  output logic [3:0]            s_hprot,
  output logic                  s_hmastlock,
  output logic [DATA_WIDTH-1:0] s_hwdata,
  input  logic [DATA_WIDTH-1:0] s_hrdata,
  input  logic                  s_hready,
  input  logic                  s_hresp
);

  // Request word layout: {addr, write, size[2:0], prot[3:0], lock}
  localparam int REQ_W = ADDR_WIDTH + 9;

  logic [REQ_W-1:0] req0, req1, pend0, pend1, sel_req, s_req_q, s_req_d;
  logic             cap0, cap1, pv0, pv1, el0, el1, slot_free;
  logic             load0, load1, clr0, clr1;
  logic [1:0]       s_htrans_q, s_htrans_d;
  owner_e           aowner_q, aowner_d, downer_q, downer_d;
  owner_e           last_q, last_d, lock_q, lock_d, win;
  logic             unused_ok;

  assign req0 = {m0_haddr, m0_hwrite, m0_hsize, m0_hprot, m0_hmastlock};
  assign req1 = {m1_haddr, m1_hwrite, m1_hsize, m1_hprot, m1_hmastlock};
  assign cap0 = m0_hready && is_req(m0_htrans);
  assign cap1 = m1_hready && is_req(m1_htrans);
  // Incoming burst types are dropped: every beat leaves as SINGLE.
  assign unused_ok = ^{m0_hburst, m1_hburst};

  ahb_arb_req_buf #(.W(REQ_W)) u_buf0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .load(load0), .clear(clr0),
    .req_i(req0), .valid_o(pv0), .req_o(pend0)
  );
  ahb_arb_req_buf #(.W(REQ_W)) u_buf1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .load(load1), .clear(clr1),
    .req_i(req1), .valid_o(pv1), .req_o(pend1)
  );

  always_comb begin
    slot_free = (s_htrans_q == HTRANS_IDLE) || s_hready;
    el0 = (pv0 || cap0) && (lock_q != OWN_M1);
    el1 = (pv1 || cap1) && (lock_q != OWN_M0);
    win = OWN_NONE;
    if (slot_free) begin
      if (el0 && el1) begin
        if (RR_EN != 0) win = (last_q == OWN_M1) ? OWN_M0 : OWN_M1;
        else            win = OWN_M1;
      end else if (el0) begin
        win = OWN_M0;
      end else if (el1) begin
        win = OWN_M1;
      end
    end
    sel_req = (win == OWN_M0) ? (pv0 ? pend0 : req0) : (pv1 ? pend1 : req1);
    load0 = cap0 && (win != OWN_M0);
    load1 = cap1 && (win != OWN_M1);
    clr0  = (win == OWN_M0);
    clr1  = (win == OWN_M1);
  end

  always_comb begin
    s_req_d    = s_req_q;
    s_htrans_d = s_htrans_q;
    aowner_d   = aowner_q;
    last_d     = last_q;
    lock_d     = lock_q;
    downer_d   = s_hready ? aowner_q : downer_q;
    if (slot_free) begin
      if (win != OWN_NONE) begin
        s_req_d    = sel_req;
        s_htrans_d = HTRANS_NONSEQ;
        aowner_d   = win;
        last_d     = win;
      end else begin
        s_htrans_d = HTRANS_IDLE;
        aowner_d   = OWN_NONE;
      end
    end
    // Lock is taken by issuing a locked beat and dropped once the owner shows an unlocked, accepted cycle.
    if (win != OWN_NONE && sel_req[0]) lock_d = win;
    else if (lock_q == OWN_M0 && m0_hready && !m0_hmastlock) lock_d = OWN_NONE;
    else if (lock_q == OWN_M1 && m1_hready && !m1_hmastlock) lock_d = OWN_NONE;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      s_req_q    <= '0;
      s_htrans_q <= HTRANS_IDLE;
      aowner_q   <= OWN_NONE;
      downer_q   <= OWN_NONE;
      last_q     <= OWN_M1;
      lock_q     <= OWN_NONE;
    end else begin
      s_req_q    <= s_req_d;
      s_htrans_q <= s_htrans_d;
      aowner_q   <= aowner_d;
      downer_q   <= downer_d;
      last_q     <= last_d;
      lock_q     <= lock_d;
    end
  end

  assign s_haddr     = s_req_q[REQ_W-1 -: ADDR_WIDTH];
  assign s_hwrite    = s_req_q[8];
  assign s_hsize     = s_req_q[7:5];
  assign s_hprot     = s_req_q[4:1];
  assign s_hmastlock = s_req_q[0];
  assign s_htrans    = s_htrans_q;
  assign s_hburst    = HBURST_SINGLE;

  always_comb begin
    s_hwdata  = '0;
    m0_hrdata = '0;
    m1_hrdata = '0;
    m0_hresp  = HRESP_OKAY;
    m1_hresp  = HRESP_OKAY;
    m0_hready = 1'b1;
    m1_hready = 1'b1;
    if (downer_q == OWN_M0) begin
      s_hwdata  = m0_hwdata;
      m0_hrdata = s_hrdata;
      m0_hresp  = s_hresp;
      m0_hready = s_hready;
    end else if (pv0 || aowner_q == OWN_M0) begin
      m0_hready = 1'b0;
    end
    if (downer_q == OWN_M1) begin
      s_hwdata  = m1_hwdata;
      m1_hrdata = s_hrdata;
      m1_hresp  = s_hresp;
      m1_hready = s_hready;
    end else if (pv1 || aowner_q == OWN_M1) begin
      m1_hready = 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share the same
// stimulus; `sel` picks which one the checks look at.
module tb_ahb_master_arbiter;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [31:0] RDATA   = 32'hDEAD_BEEF;
  localparam logic [31:0] WDATA   = 32'h1234_5678;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, s_hrdata;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite, m0_hmastlock, m1_hmastlock;
  logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;
  logic        s_hready, s_hresp;

  logic [31:0] m0_hrdata_w[2], m1_hrdata_w[2], s_haddr_w[2], s_hwdata_w[2];
  logic        m0_hready_w[2], m0_hresp_w[2], m1_hready_w[2], m1_hresp_w[2];
  logic        s_hwrite_w[2], s_hmastlock_w[2];
  logic [1:0]  s_htrans_w[2];
  logic [2:0]  s_hsize_w[2], s_hburst_w[2];
  logic [3:0]  s_hprot_w[2];

  int sel = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 HCLK = ~HCLK;

  ahb_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_EN(1)) dut_rr (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite),
    .m0_hmastlock(m0_hmastlock), .m0_hsize(m0_hsize), .m0_hburst(m0_hburst),
    .m0_hprot(m0_hprot), .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata_w[0]),
    .m0_hready(m0_hready_w[0]), .m0_hresp(m0_hresp_w[0]),
    .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite),
    .m1_hmastlock(m1_hmastlock), .m1_hsize(m1_hsize), .m1_hburst(m1_hburst),
    .m1_hprot(m1_hprot), .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata_w[0]),
    .m1_hready(m1_hready_w[0]), .m1_hresp(m1_hresp_w[0]),
    .s_haddr(s_haddr_w[0]), .s_hwrite(s_hwrite_w[0]), .s_htrans(s_htrans_w[0]),
    .s_hsize(s_hsize_w[0]), .s_hburst(s_hburst_w[0]), .s_hprot(s_hprot_w[0]),
    .s_hmastlock(s_hmastlock_w[0]), .s_hwdata(s_hwdata_w[0]),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  ahb_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_EN(0)) dut_fp (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite),
    .m0_hmastlock(m0_hmastlock), .m0_hsize(m0_hsize), .m0_hburst(m0_hburst),
    .m0_hprot(m0_hprot), .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata_w[1]),
    .m0_hready(m0_hready_w[1]), .m0_hresp(m0_hresp_w[1]),
    .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite),
    .m1_hmastlock(m1_hmastlock), .m1_hsize(m1_hsize), .m1_hburst(m1_hburst),
    .m1_hprot(m1_hprot), .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata_w[1]),
    .m1_hready(m1_hready_w[1]), .m1_hresp(m1_hresp_w[1]),
    .s_haddr(s_haddr_w[1]), .s_hwrite(s_hwrite_w[1]), .s_htrans(s_htrans_w[1]),
    .s_hsize(s_hsize_w[1]), .s_hburst(s_hburst_w[1]), .s_hprot(s_hprot_w[1]),
    .s_hmastlock(s_hmastlock_w[1]), .s_hwdata(s_hwdata_w[1]),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle;
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle;
    @(negedge HCLK);
  endtask

  task automatic drv_m0(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic lk);
    m0_htrans = tr; m0_haddr = a; m0_hwrite = w; m0_hmastlock = lk;
  endtask

  task automatic drv_m1(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic lk);
    m1_htrans = tr; m1_haddr = a; m1_hwrite = w; m1_hmastlock = lk;
  endtask

  task automatic do_reset;
    HRESETn = 1'b0;
    drv_m0(T_IDLE, 32'h0, 1'b0, 1'b0);
    drv_m1(T_IDLE, 32'h0, 1'b0, 1'b0);
    m0_hwdata = 32'h0; m1_hwdata = 32'h0;
    s_hready = 1'b1; s_hresp = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  task automatic single_m0(input logic [31:0] a);
    drv_m0(T_NONSEQ, a, 1'b0, 1'b0);
    settle;
    chk("single_m0_rdy_req", m0_hready_w[sel], 1);
    next_cycle;
    drv_m0(T_IDLE, 32'h0, 1'b0, 1'b0);
    settle;
    chk("single_s_htrans", s_htrans_w[sel], T_NONSEQ);
    chk("single_s_haddr", s_haddr_w[sel], a);
    chk("single_s_hburst", s_hburst_w[sel], 0);
    chk("single_s_hsize", s_hsize_w[sel], 2);
    chk("single_s_hprot", s_hprot_w[sel], 3);
    chk("single_m0_rdy_aph", m0_hready_w[sel], 0);
    chk("single_m1_rdy_aph", m1_hready_w[sel], 1);
    next_cycle;
    settle;
    chk("single_m0_rdy_dph", m0_hready_w[sel], 1);
    chk("single_m0_hrdata", m0_hrdata_w[sel], RDATA);
    chk("single_m1_rdy_dph", m1_hready_w[sel], 1);
    chk("single_m1_hrdata", m1_hrdata_w[sel], 0);
    chk("single_s_idle", s_htrans_w[sel], T_IDLE);
    next_cycle;
  endtask

  task automatic sim_pair(input logic m1_first);
    drv_m0(T_NONSEQ, 32'h0000_0100, 1'b0, 1'b0);
    drv_m1(T_NONSEQ, 32'h8000_0000, 1'b1, 1'b0);
    m1_hwdata = 32'h0;
    settle;
    chk("pair_m0_rdy_req", m0_hready_w[sel], 1);
    chk("pair_m1_rdy_req", m1_hready_w[sel], 1);
    next_cycle;
    drv_m0(T_IDLE, 32'h0, 1'b0, 1'b0);
    drv_m1(T_IDLE, 32'h0, 1'b0, 1'b0);
    m1_hwdata = WDATA;
    settle;
    chk("pair_first_htrans", s_htrans_w[sel], T_NONSEQ);
    chk("pair_first_haddr", s_haddr_w[sel], m1_first ? 32'h8000_0000 : 32'h0000_0100);
    chk("pair_m0_rdy_b", m0_hready_w[sel], 0);
    chk("pair_m1_rdy_b", m1_hready_w[sel], 0);
    next_cycle;
    settle;
    chk("pair_second_haddr", s_haddr_w[sel], m1_first ? 32'h0000_0100 : 32'h8000_0000);
    chk("pair_second_htrans", s_htrans_w[sel], T_NONSEQ);
    if (m1_first) begin
      chk("pair_m1_rdy_first", m1_hready_w[sel], 1);
      chk("pair_hwdata_first", s_hwdata_w[sel], WDATA);
      chk("pair_m0_rdy_wait", m0_hready_w[sel], 0);
    end else begin
      chk("pair_m0_rdy_first", m0_hready_w[sel], 1);
      chk("pair_m0_hrdata_first", m0_hrdata_w[sel], RDATA);
      chk("pair_m1_rdy_wait", m1_hready_w[sel], 0);
      chk("pair_m1_hrdata_gated", m1_hrdata_w[sel], 0);
    end
    next_cycle;
    settle;
    chk("pair_idle_after", s_htrans_w[sel], T_IDLE);
    if (m1_first) begin
      chk("pair_m0_rdy_second", m0_hready_w[sel], 1);
      chk("pair_m0_hrdata_second", m0_hrdata_w[sel], RDATA);
    end else begin
      chk("pair_m1_rdy_second", m1_hready_w[sel], 1);
      chk("pair_hwdata_second", s_hwdata_w[sel], WDATA);
    end
    next_cycle;
  endtask

  initial begin
    m0_hsize = 3'b010; m1_hsize = 3'b010;
    m0_hprot = 4'b0011; m1_hprot = 4'b0011;
    m0_hburst = 3'b001; m1_hburst = 3'b001;
    s_hrdata = RDATA;

    // Reset state and round-robin ordering.
    sel = 0;
    do_reset;
    settle;
    chk("rst_s_htrans", s_htrans_w[sel], T_IDLE);
    chk("rst_s_haddr", s_haddr_w[sel], 0);
    chk("rst_m0_hready", m0_hready_w[sel], 1);
    chk("rst_m1_hready", m1_hready_w[sel], 1);
    chk("rst_m0_hrdata", m0_hrdata_w[sel], 0);
    chk("rst_m0_hresp", m0_hresp_w[sel], 0);
    next_cycle;
    do_reset;
    sim_pair(1'b0);
    sim_pair(1'b0);
    single_m0(32'h0000_0040);
    sim_pair(1'b1);

    // Wait states on an M1 write address phase while M0 requests.
    drv_m1(T_NONSEQ, 32'h8000_0010, 1'b1, 1'b0);
    settle;
    chk("ws_m1_rdy_req", m1_hready_w[sel], 1);
    next_cycle;
    drv_m1(T_IDLE, 32'h0, 1'b0, 1'b0);
    m1_hwdata = WDATA;
    s_hready = 1'b0;
    drv_m0(T_NONSEQ, 32'h0000_0200, 1'b0, 1'b0);
    settle;
    chk("ws_haddr_b", s_haddr_w[sel], 32'h8000_0010);
    chk("ws_m0_rdy_b", m0_hready_w[sel], 1);
    next_cycle;
    drv_m0(T_IDLE, 32'h0, 1'b0, 1'b0);
    settle;
    chk("ws_haddr_c", s_haddr_w[sel], 32'h8000_0010);
    chk("ws_htrans_c", s_htrans_w[sel], T_NONSEQ);
    chk("ws_m0_rdy_c", m0_hready_w[sel], 0);
    chk("ws_m1_rdy_c", m1_hready_w[sel], 0);
    next_cycle;
    settle;
    chk("ws_haddr_d", s_haddr_w[sel], 32'h8000_0010);
    chk("ws_hwrite_d", s_hwrite_w[sel], 1);
    chk("ws_m0_rdy_d", m0_hready_w[sel], 0);
    next_cycle;
    s_hready = 1'b1;
    settle;
    chk("ws_haddr_e", s_haddr_w[sel], 32'h8000_0010);
    chk("ws_m1_rdy_e", m1_hready_w[sel], 0);
    next_cycle;
    settle;
    chk("ws_haddr_f", s_haddr_w[sel], 32'h0000_0200);
    chk("ws_hwrite_f", s_hwrite_w[sel], 0);
    chk("ws_hwdata_f", s_hwdata_w[sel], WDATA);
    chk("ws_m1_rdy_f", m1_hready_w[sel], 1);
    chk("ws_m0_rdy_f", m0_hready_w[sel], 0);
    next_cycle;
    settle;
    chk("ws_m0_rdy_g", m0_hready_w[sel], 1);
    chk("ws_m0_hrdata_g", m0_hrdata_w[sel], RDATA);
    chk("ws_idle_g", s_htrans_w[sel], T_IDLE);
    next_cycle;

    // Locked M1 sequence keeps M0 out until the lock is dropped.
    drv_m1(T_NONSEQ, 32'h8000_0004, 1'b1, 1'b1);
    settle;
    chk("lk_m1_rdy_a", m1_hready_w[sel], 1);
    next_cycle;
    drv_m1(T_NONSEQ, 32'h8000_0008, 1'b1, 1'b1);
    drv_m0(T_NONSEQ, 32'h0000_0100, 1'b0, 1'b0);
    settle;
    chk("lk_haddr_b", s_haddr_w[sel], 32'h8000_0004);
    chk("lk_hmastlock_b", s_hmastlock_w[sel], 1);
    chk("lk_m0_rdy_b", m0_hready_w[sel], 1);
    next_cycle;
    drv_m0(T_IDLE, 32'h0, 1'b0, 1'b0);
    settle;
    chk("lk_idle_c", s_htrans_w[sel], T_IDLE);
    chk("lk_m0_rdy_c", m0_hready_w[sel], 0);
    chk("lk_m1_rdy_c", m1_hready_w[sel], 1);
    next_cycle;
    drv_m1(T_IDLE, 32'h0, 1'b0, 1'b0);
    settle;
    chk("lk_haddr_d", s_haddr_w[sel], 32'h8000_0008);
    chk("lk_hmastlock_d", s_hmastlock_w[sel], 1);
    chk("lk_m0_rdy_d", m0_hready_w[sel], 0);
    next_cycle;
    settle;
    chk("lk_idle_e", s_htrans_w[sel], T_IDLE);
    chk("lk_m0_rdy_e", m0_hready_w[sel], 0);
    next_cycle;
    settle;
    chk("lk_idle_f", s_htrans_w[sel], T_IDLE);
    chk("lk_m0_rdy_f", m0_hready_w[sel], 0);
    next_cycle;
    settle;
    chk("lk_haddr_g", s_haddr_w[sel], 32'h0000_0100);
    chk("lk_htrans_g", s_htrans_w[sel], T_NONSEQ);
    chk("lk_hmastlock_g", s_hmastlock_w[sel], 0);
    next_cycle;
    settle;
    chk("lk_m0_rdy_h", m0_hready_w[sel], 1);
    next_cycle;

    // Two-cycle ERROR response on an M0 transfer.
    drv_m0(T_NONSEQ, 32'h0000_0040, 1'b0, 1'b0);
    settle;
    next_cycle;
    drv_m0(T_IDLE, 32'h0, 1'b0, 1'b0);
    settle;
    chk("err_htrans_b", s_htrans_w[sel], T_NONSEQ);
    next_cycle;
    s_hready = 1'b0; s_hresp = 1'b1;
    settle;
    chk("err_m0_rdy_1", m0_hready_w[sel], 0);
    chk("err_m0_resp_1", m0_hresp_w[sel], 1);
    chk("err_m1_resp_1", m1_hresp_w[sel], 0);
    chk("err_m1_rdy_1", m1_hready_w[sel], 1);
    next_cycle;
    s_hready = 1'b1;
    settle;
    chk("err_m0_rdy_2", m0_hready_w[sel], 1);
    chk("err_m0_resp_2", m0_hresp_w[sel], 1);
    chk("err_m1_resp_2", m1_hresp_w[sel], 0);
    next_cycle;
    s_hresp = 1'b0;
    settle;
    chk("err_m0_resp_end", m0_hresp_w[sel], 0);
    next_cycle;

    // Reset during an M1 data phase with M0 in the address phase.
    drv_m1(T_NONSEQ, 32'h8000_0020, 1'b1, 1'b0);
    settle;
    next_cycle;
    drv_m1(T_IDLE, 32'h0, 1'b0, 1'b0);
    m1_hwdata = 32'hCAFE_0001;
    s_hready = 1'b0;
    drv_m0(T_NONSEQ, 32'h0000_0100, 1'b0, 1'b0);
    settle;
    chk("rm_m0_rdy_b", m0_hready_w[sel], 1);
    next_cycle;
    drv_m0(T_IDLE, 32'h0, 1'b0, 1'b0);
    s_hready = 1'b1;
    settle;
    chk("rm_m0_rdy_pend", m0_hready_w[sel], 0);
    next_cycle;
    s_hready = 1'b0;
    settle;
    chk("rm_haddr_d", s_haddr_w[sel], 32'h0000_0100);
    chk("rm_hwdata_d", s_hwdata_w[sel], 32'hCAFE_0001);
    chk("rm_m1_rdy_d", m1_hready_w[sel], 0);
    HRESETn = 1'b0;
    next_cycle;
    HRESETn = 1'b1;
    s_hready = 1'b1; s_hresp = 1'b1;
    settle;
    chk("rm_htrans_rst", s_htrans_w[sel], T_IDLE);
    chk("rm_haddr_rst", s_haddr_w[sel], 0);
    chk("rm_m0_rdy_rst", m0_hready_w[sel], 1);
    chk("rm_m1_rdy_rst", m1_hready_w[sel], 1);
    chk("rm_m1_resp_rst", m1_hresp_w[sel], 0);
    chk("rm_m0_hrdata_rst", m0_hrdata_w[sel], 0);
    chk("rm_hwdata_rst", s_hwdata_w[sel], 0);
    next_cycle;
    s_hresp = 1'b0;
    settle;
    chk("rm_no_ghost", s_htrans_w[sel], T_IDLE);
    next_cycle;

    // Fixed priority: M1 wins every tie.
    sel = 1;
    do_reset;
    sim_pair(1'b1);
    sim_pair(1'b1);
    single_m0(32'h0000_0040);
    sim_pair(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
